// File: rtl/reg_file_if.sv
// -----------------------------------------------------------------------------
// reg_file_if
//   Bus bundle for reg_file: one write port and READ_PORTS read ports.
//   Every signal is a packed flat vector, so a plain-Verilog wrapper can map
//   it straight onto discrete wires.
//
//   Signals
//     wr_en_i     write enable
//     wr_addr_i   write address                      [ADDR_WIDTH-1:0]
//     wr_data_i   write data                         [WIDTH-1:0]
//     rd_addr_i   packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//     rd_data_o   packed read data,      port p at [p*WIDTH +: WIDTH]
//
//   Modports
//     master  the user of the register file (drives addresses and write data)
//     slave   the register file itself
// -----------------------------------------------------------------------------
interface reg_file_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) ();

    logic                             wr_en_i;
    logic [ADDR_WIDTH-1:0]            wr_addr_i;
    logic [WIDTH-1:0]                 wr_data_i;
    logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr_i;
    logic [READ_PORTS*WIDTH-1:0]      rd_data_o;

    modport master (
        output wr_en_i,
        output wr_addr_i,
        output wr_data_i,
        output rd_addr_i,
        input  rd_data_o
    );

    modport slave (
        input  wr_en_i,
        input  wr_addr_i,
        input  wr_data_i,
        input  rd_addr_i,
        output rd_data_o
    );

endinterface : reg_file_if

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   Multi-read-port, single-write-port register file for a CPU integer core.
//   Reads are combinational with zero latency and no write-to-read bypass:
//   a read of the entry being written shows the old value until the clock
//   edge. When ZERO_REG=1, entry 0 always reads as zero and writes to it are
//   dropped. When DEPTH is not a power of two, addresses >= DEPTH read as zero
//   and writes to them are dropped (no wrap-around).
//
//   Ports
//     clk_i   clock, all state changes on the rising edge
//     rst_i   asynchronous active-high reset, clears every entry immediately
//     bus     reg_file_if.slave: write port and packed read ports
//
//   Parameters
//     WIDTH       entry width in bits (>=1)
//     DEPTH       number of entries (>=2)
//     ZERO_REG    1: entry 0 hardwired to zero, 0: ordinary register
//     READ_PORTS  number of independent read ports (>=1)
//     ADDR_WIDTH  derived from DEPTH, not overridable
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int ZERO_REG   = 1,
    parameter int READ_PORTS = 2,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic       clk_i,
    input logic       rst_i,
    reg_file_if.slave bus
);

    // One extra bit so the range check also works when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam bit                  HAS_ZERO  = (ZERO_REG != 0);

    logic [WIDTH-1:0]            mem [DEPTH];
    logic                        wr_ok;
    logic [READ_PORTS*WIDTH-1:0] rd_data;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < DEPTH_EXT;
    endfunction

    // Out-of-range and hardwired-zero addresses never index the array, so no
    // X can leak onto a read port.
    function automatic logic [WIDTH-1:0] read_entry(input logic [ADDR_WIDTH-1:0] addr);
        if (!in_range(addr) || (HAS_ZERO && addr == '0)) begin
            return '0;
        end
        return mem[addr];
    endfunction

    assign wr_ok = bus.wr_en_i
                && in_range(bus.wr_addr_i)
                && !(HAS_ZERO && bus.wr_addr_i == '0);

    // NOTE: the array carries the asynchronous reset on purpose: reads after
    // reset must be defined zeros, so this storage maps to flops, not RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking for all sequential state, so every
                // reader in the same time step sees the pre-edge value.
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.wr_addr_i] <= bus.wr_data_i;
        end
    end

    always_comb begin
        // NOTE: default the whole vector first so no path leaves bits
        // unassigned and infers a latch.
        rd_data = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_data[p*WIDTH +: WIDTH] = read_entry(bus.rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    assign bus.rd_data_o = rd_data;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//   Two register files side by side: dut0 is the default CPU configuration
//   (32 x 32, zero register, 2 read ports); dut1 has no zero register,
//   12 entries (not a power of two) and 3 read ports. Directed steps come
//   first, then a randomized phase checked against an array model that
//   applies the write/read rules directly.
// -----------------------------------------------------------------------------
module tb_reg_file;

    localparam int W   = 32;
    localparam int D0  = 32;
    localparam int D1  = 12;
    localparam int RP0 = 2;
    localparam int RP1 = 3;
    localparam int AW0 = 5;
    localparam int AW1 = 4;

    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    reg_file_if #(.WIDTH(W), .DEPTH(D0), .READ_PORTS(RP0)) bus0 ();
    reg_file_if #(.WIDTH(W), .DEPTH(D1), .READ_PORTS(RP1)) bus1 ();

    reg_file #(.WIDTH(W), .DEPTH(D0), .ZERO_REG(1), .READ_PORTS(RP0)) dut0 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus0.slave)
    );

    reg_file #(.WIDTH(W), .DEPTH(D1), .ZERO_REG(0), .READ_PORTS(RP1)) dut1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus1.slave)
    );

    // Reference model: plain arrays indexed by register number.
    logic [W-1:0] m0 [D0];
    logic [W-1:0] m1 [D1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp0(input int a);
        if (a == 0) return '0;
        return m0[a];
    endfunction

    function automatic logic [W-1:0] exp1(input int a);
        if (a >= D1) return '0;
        return m1[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < D0; i++) m0[i] = '0;
        for (int i = 0; i < D1; i++) m1[i] = '0;
    endtask

    task automatic set_rd0(input int p, input int a);
        bus0.rd_addr_i[p*AW0 +: AW0] = AW0'(a);
    endtask

    task automatic set_rd1(input int p, input int a);
        bus1.rd_addr_i[p*AW1 +: AW1] = AW1'(a);
    endtask

    function automatic logic [W-1:0] rd0(input int p);
        return bus0.rd_data_o[p*W +: W];
    endfunction

    function automatic logic [W-1:0] rd1(input int p);
        return bus1.rd_data_o[p*W +: W];
    endfunction

    task automatic drive_wr(input logic en0, input int a0, input logic [W-1:0] d0,
                            input logic en1, input int a1, input logic [W-1:0] d1);
        bus0.wr_en_i   = en0;
        bus0.wr_addr_i = AW0'(a0);
        bus0.wr_data_i = d0;
        bus1.wr_en_i   = en1;
        bus1.wr_addr_i = AW1'(a1);
        bus1.wr_data_i = d1;
    endtask

    // Advance one rising edge; the model commits whatever write the rules
    // allow for the inputs present at that edge. Returns 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        if (!rst_i) begin
            if (bus0.wr_en_i && bus0.wr_addr_i != 0)
                m0[bus0.wr_addr_i] = bus0.wr_data_i;
            if (bus1.wr_en_i && int'(bus1.wr_addr_i) < D1)
                m1[bus1.wr_addr_i] = bus1.wr_data_i;
        end
        #1;
    endtask

    // Compare every read port of both DUTs against the model.
    task automatic check_all(input string tag);
        for (int p = 0; p < RP0; p++)
            check($sformatf("%s dut0 p%0d a%0d", tag, p, bus0.rd_addr_i[p*AW0 +: AW0]),
                  rd0(p), exp0(int'(bus0.rd_addr_i[p*AW0 +: AW0])));
        for (int p = 0; p < RP1; p++)
            check($sformatf("%s dut1 p%0d a%0d", tag, p, bus1.rd_addr_i[p*AW1 +: AW1]),
                  rd1(p), exp1(int'(bus1.rd_addr_i[p*AW1 +: AW1])));
    endtask

    task automatic point_all(input int a);
        for (int p = 0; p < RP0; p++) set_rd0(p, a);
        for (int p = 0; p < RP1; p++) set_rd1(p, a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] pat;

        // ---- Reset held for 5 cycles, then released --------------------------
        rst_i = 1'b1;
        model_clear();
        drive_wr(1'b0, 0, '0, 1'b0, 0, '0);
        point_all(0);
        repeat (5) tick();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        for (int a = 0; a < 8; a++) begin
            point_all(a);
            #1;
            check_all("reset_clear");
        end

        // ---- Write during reset ignored; write held across release takes ----
        @(negedge clk_i);
        rst_i = 1'b1;
        drive_wr(1'b1, 9, 32'h9999_0009, 1'b1, 9, 32'h9999_1009);
        point_all(9);
        tick();
        check("wr_in_reset dut0", rd0(0), 32'h0);
        check("wr_in_reset dut1", rd1(0), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        check("wr_after_release dut0", rd0(1), 32'h9999_0009);
        check("wr_after_release dut1", rd1(2), 32'h9999_1009);

        // ---- Zero register ---------------------------------------------------
        drive_wr(1'b1, 0, 32'hDEAD_BEEF, 1'b0, 0, '0);
        tick();
        drive_wr(1'b0, 0, '0, 1'b0, 0, '0);
        point_all(0);
        #1;
        check("zero_reg dut0 p0", rd0(0), 32'h0000_0000);

        // ---- Write i*0x11111111 to 1..7 on consecutive cycles ----------------
        for (int i = 1; i < 8; i++) begin
            pat = W'(i) * 32'h1111_1111;
            drive_wr(1'b1, i, pat, 1'b1, i, pat);
            tick();
        end
        drive_wr(1'b0, 0, '0, 1'b0, 0, '0);
        for (int i = 1; i < 8; i++) begin
            pat = W'(i) * 32'h1111_1111;
            point_all(i);
            #1;
            check($sformatf("readback dut0 p0 a%0d", i), rd0(0), pat);
            check($sformatf("readback dut0 p1 a%0d", i), rd0(1), pat);
            check($sformatf("readback dut1 p2 a%0d", i), rd1(2), pat);
        end

        // ---- Dual-port independence -----------------------------------------
        set_rd0(0, 3);
        set_rd0(1, 5);
        #1;
        check("dual dut0 p0 a3", rd0(0), 32'h3333_3333);
        check("dual dut0 p1 a5", rd0(1), 32'h5555_5555);

        // ---- Read-during-write: old value before the edge, new after --------
        point_all(4);
        drive_wr(1'b1, 4, 32'hCAFE_F00D, 1'b1, 4, 32'hCAFE_F00D);
        #1;
        check("rdw_before dut0", rd0(0), 32'h4444_4444);
        check("rdw_before dut1", rd1(1), 32'h4444_4444);
        tick();
        check("rdw_after dut0", rd0(0), 32'hCAFE_F00D);
        check("rdw_after dut1", rd1(1), 32'hCAFE_F00D);

        // ---- Write enable low leaves the entry alone -------------------------
        drive_wr(1'b0, 6, 32'h1234_5678, 1'b0, 6, 32'h1234_5678);
        point_all(6);
        tick();
        check("wr_en_low dut0", rd0(1), 32'h6666_6666);
        check("wr_en_low dut1", rd1(0), 32'h6666_6666);

        // ---- ZERO_REG=0: entry 0 is an ordinary register --------------------
        drive_wr(1'b0, 0, '0, 1'b1, 0, 32'hA5A5_A5A5);
        point_all(0);
        tick();
        check("no_zero_reg dut1", rd1(0), 32'hA5A5_A5A5);
        check("zero_reg_still dut0", rd0(0), 32'h0);

        // ---- Out of range on the 12-entry instance --------------------------
        drive_wr(1'b0, 0, '0, 1'b1, 13, 32'h0000_0BAD);
        set_rd1(0, 13);
        set_rd1(1, 5);
        set_rd1(2, 1);
        tick();
        check("oor_read dut1 a13", rd1(0), 32'h0);
        check("oor_no_alias dut1 a5", rd1(1), 32'h5555_5555);
        check("oor_no_alias dut1 a1", rd1(2), 32'h1111_1111);
        drive_wr(1'b0, 0, '0, 1'b0, 0, '0);

        // ---- Asynchronous reset mid-cycle ------------------------------------
        set_rd0(0, 3);
        set_rd0(1, 7);
        set_rd1(0, 0);
        set_rd1(1, 3);
        set_rd1(2, 7);
        #2;
        check("pre_async dut0 p0", rd0(0), 32'h3333_3333);
        rst_i = 1'b1;
        model_clear();
        #1;
        check_all("async_reset");
        tick();
        @(negedge clk_i);
        rst_i = 1'b0;

        // ---- Randomized traffic against the model ---------------------------
        for (int n = 0; n < 300; n++) begin
            drive_wr(1'($urandom_range(0, 3) != 0), $urandom_range(0, D0 - 1), W'($urandom()),
                     1'($urandom_range(0, 3) != 0), $urandom_range(0, 15), W'($urandom()));
            for (int p = 0; p < RP0; p++) set_rd0(p, $urandom_range(0, D0 - 1));
            for (int p = 0; p < RP1; p++) set_rd1(p, $urandom_range(0, 15));
            if (n % 8 == 0) begin
                // Same-address read on port 0 to exercise read-during-write.
                bus0.rd_addr_i[0 +: AW0] = bus0.wr_addr_i;
                bus1.rd_addr_i[0 +: AW1] = bus1.wr_addr_i;
            end
            #1;
            check_all("rand_pre");
            tick();
            check_all("rand_post");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
Name: reg_file

Overview:
Multi-read-port, single-write-port register file with an optional hardwired-zero entry 0, as used for a CPU integer register file. Reads are combinational. Writes occur on the rising clock edge. All ports are packed flat vectors so the block can be instantiated from plain Verilog.

Parameters:
- WIDTH, 32, data width of each entry in bits (>=1).
- DEPTH, 32, number of entries (>=2; need not be a power of two).
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero; when 0 entry 0 is an ordinary register.
- READ_PORTS, 2, number of independent read ports (>=1).
- ADDR_WIDTH, $clog2(DEPTH), address width; derived, not to be overridden.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- wr_en_i  input  1  write enable.
- wr_addr_i  input  ADDR_WIDTH  write address.
- wr_data_i  input  WIDTH  write data.
- rd_addr_i  input  READ_PORTS*ADDR_WIDTH  packed read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data_o  output  READ_PORTS*WIDTH  packed read data; port p drives bits [p*WIDTH +: WIDTH].

Behaviour:
- Reset:
  - rst_i high clears every entry to 0 immediately, with no clock required.
  - While reset is asserted, all rd_data_o slices read 0.
  - Writes are ignored while rst_i is high.
  - A write coincident with reset deassertion takes effect only on the first rising edge at which rst_i is low.
- Write:
  - On a rising edge with rst_i=0 and wr_en_i=1, mem[wr_addr_i] <= wr_data_i.
  - With wr_en_i=0, no entry changes.
- Zero register: when ZERO_REG=1, writes to address 0 are discarded and every read of address 0 returns 0.
- Read:
  - Each read port is purely combinational: rd_data_o[p] = mem[rd_addr_i[p]].
  - Zero latency; a changed address is reflected in the same cycle.
- Read-during-write (same address, same cycle): the read port returns the old contents until the clock edge, then the new value. No write-to-read bypass.
- Multiple read ports may address the same entry simultaneously; each returns identical data.
- Out of range: when DEPTH is not a power of two, addresses >= DEPTH read as 0 and writes to them are ignored. No wrap-around and no X propagation.
- Storage has no initial value other than that established by reset. Outputs never show X after the first reset.

Test Plan:
- Reset:
  - Hold rst_i=1 for 5 cycles, release.
  - All ports reading addresses 0..7 -> 0.
  - Assert rst_i asynchronously mid-cycle after writes -> rd_data_o drops to 0 before the next edge.
- Zero register (ZERO_REG=1):
  - Write 0xDEADBEEF to address 0.
  - Read port 0 at address 0 -> 0x00000000.
- Write/read back:
  - Write i*0x11111111 to addresses 1..7 on consecutive cycles.
  - Read each on port 0 -> 0x11111111 … 0x77777777.
  - Port 1 on the same addresses -> identical values.
- Dual-port independence:
  - Port 0 at address 3, port 1 at address 5 in the same cycle -> 0x33333333 and 0x55555555 respectively.
- Read-during-write and write enable:
  - Address 4 holds 0x44444444; write 0xCAFEF00D to address 4 while reading it -> 0x44444444 before the edge, 0xCAFEF00D after.
  - With wr_en_i=0 and wr_data_i=0x12345678 at address 6 -> address 6 unchanged (0x66666666).
- ZERO_REG=0 variant: write 0xA5A5A5A5 to address 0 -> reads back 0xA5A5A5A5.
